half_sub: RTL and testbench
===========================

HALF_SUB -- requirements
Module: half_sub

Interface
REQ-001 SHALL provide parameter WIDTH, default 1, operand and difference width in bits (legal range 1..32).
REQ-002 SHALL provide parameter CNT_W, default 16, width of the borrow event counter.
REQ-003 SHALL provide port clk  input  1  the single rising-edge clock; all state changes on this edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port a  input  WIDTH  minuend.
REQ-006 SHALL provide port b  input  WIDTH  subtrahend.
REQ-007 SHALL provide port in_valid  input  1  a/b qualify this cycle.
REQ-008 SHALL provide port d  output  WIDTH  registered difference.
REQ-009 SHALL provide port bo  output  1  registered borrow-out.
REQ-010 SHALL provide port out_valid  output  1  d/bo qualify this cycle.
REQ-011 SHALL provide port cnt_clr  input  1  borrow counter clear; present only with HALF_SUB_BCNT_EN.
REQ-012 SHALL provide port borrow_cnt  output  CNT_W  borrow event count; present only with HALF_SUB_BCNT_EN.

Function
REQ-013 d SHALL equal (a - b) modulo 2^WIDTH, both operands unsigned.
REQ-014 bo SHALL be 1 exactly when a < b (unsigned), else 0.
REQ-015 For WIDTH=1: d SHALL equal a XOR b and bo SHALL equal (NOT a) AND b, so a,b = 00->d0 bo0, 01->d1 bo1, 10->d1 bo0, 11->d0 bo0.
REQ-016 Latency SHALL be exactly one clock: a/b sampled on edge N with in_valid=1 appear on d/bo with out_valid=1 after edge N.
REQ-017 out_valid SHALL be in_valid delayed by one clock; there is no back-pressure and every valid input SHALL produce one valid output.
REQ-018 When in_valid=0, d and bo SHALL hold their previous values; out_valid SHALL drop to 0.
REQ-019 Back-to-back valid inputs SHALL produce back-to-back valid outputs, one result per clock.
REQ-020 X/Z on a or b with in_valid=0 SHALL NOT disturb d/bo.

Reset
REQ-021 On a clock edge with rst=1, d SHALL become 0, bo 0, out_valid 0 and borrow_cnt 0, regardless of in_valid.
REQ-022 rst SHALL have priority over in_valid and cnt_clr; an input presented in the same cycle as rst SHALL be discarded.
REQ-023 The first edge after rst deasserts SHALL process inputs normally.

Configuration
REQ-024 Macro HALF_SUB_BCNT_EN SHALL compile in the borrow event counter, cnt_clr and borrow_cnt.
REQ-025 With HALF_SUB_BCNT_EN: borrow_cnt SHALL increment by 1 on each edge that registers a valid result with bo=1, and SHALL saturate at 2^CNT_W-1.
REQ-026 With HALF_SUB_BCNT_EN: cnt_clr=1 SHALL zero borrow_cnt on that edge; a simultaneous borrow event SHALL be dropped, since clear wins.
REQ-027 Without HALF_SUB_BCNT_EN: cnt_clr and borrow_cnt SHALL be absent, and d/bo/out_valid behaviour SHALL be identical.

Structure
REQ-028 A shared package half_sub_pkg SHALL hold the WIDTH/CNT_W defaults and the counter saturation constant.
REQ-029 A single sub-module sub_bit (1-bit full subtractor: x, y, bin -> diff, bout) SHALL be instantiated WIDTH times as a ripple-borrow chain with bin=0 at bit 0; the final bout SHALL be bo before the register.
REQ-030 The only registers SHALL be d, bo, out_valid and, when enabled, borrow_cnt.

Verification
REQ-031 WIDTH=1, rst high 2 cycles, then valid a,b = 00,01,10,11 on successive cycles -> one cycle later d/bo = 0/0, 1/1, 1/0, 0/0 with out_valid=1 each cycle.
REQ-032 WIDTH=8, a=8'h05, b=8'h07 valid -> next cycle d=8'hFE, bo=1; then a=8'hFF, b=8'h01 -> d=8'hFE, bo=0.
REQ-033 Valid input 01, then in_valid=0 for 3 cycles -> d=1, bo=1 held and out_valid=0 for those 3 cycles.
REQ-034 rst=1 in the same cycle as valid input 01 -> next cycle d=0, bo=0, out_valid=0.
REQ-035 HALF_SUB_BCNT_EN, CNT_W=2, five valid borrow inputs -> borrow_cnt goes 1,2,3,3,3; then cnt_clr with a borrow input -> borrow_cnt=0.
REQ-036 Random WIDTH=4 operands, 1000 cycles with random in_valid -> d/bo/out_valid match a one-cycle-delayed reference model on every cycle.

Source files
------------

// File: rtl/half_sub_pkg.sv
// Purpose: shared defaults and constants for the half_sub subtractor slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package half_sub_pkg;

    // Default operand/difference width in bits (legal 1..32).
    localparam int WIDTH_DEF = 1;

    // Default width of the borrow event counter.
    localparam int CNT_W_DEF = 16;

    // Saturation value of a counter built at the default width.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

    // Legal parameter ranges, shared by the top-level elaboration check.
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/half_sub_sub_bit.sv
// Purpose: 1-bit full subtractor cell (x - y - bin) for the ripple-borrow chain.
// Latency: combinational, zero cycles.
// Backpressure: none.
module sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Borrow out when y exceeds x, or when x equals y and a borrow ripples in.
    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/half_sub.sv
// Purpose: registered unsigned subtractor d = a - b with borrow-out; HALF_SUB_BCNT_EN adds a borrow event counter.
// Latency: one clock from in_valid to out_valid.
// Backpressure: none; every valid input yields exactly one valid output.
module half_sub
    import half_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             out_valid
`ifdef HALF_SUB_BCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] borrow_cnt
`endif
);

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || CNT_W < 1) begin : g_param_check
        $error("half_sub: WIDTH must be 1..32 and CNT_W at least 1");
    end

    // Ripple-borrow chain: brw[i] is the borrow into bit i, brw[WIDTH] the final borrow-out.
    logic [WIDTH:0]   brw;
    logic [WIDTH-1:0] diff_c;

    assign brw[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sub_bit u_bit (
            .x    (a[i]),
            .y    (b[i]),
            .bin  (brw[i]),
            .diff (diff_c[i]),
            .bout (brw[i+1])
        );
    end

    // Result registers: capture only on valid input so d/bo hold otherwise; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            d         <= '0;
            bo        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d  <= diff_c;
                bo <= brw[WIDTH];
            end
        end
    end

`ifdef HALF_SUB_BCNT_EN
    // All-ones value at which the counter stops.
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    // Borrow event counter: reset, then clear, take priority over a coinciding borrow event.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_cnt <= '0;
        end else if (cnt_clr) begin
            borrow_cnt <= '0;
        end else if (in_valid && brw[WIDTH] && (borrow_cnt != CNT_SAT)) begin
            borrow_cnt <= borrow_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_half_sub.sv
// Purpose: directed self-checking bench for half_sub at WIDTH 1, 8 and 4 (counter checks when HALF_SUB_BCNT_EN).
// Latency: expects results one clock after inputs.
// Backpressure: none to model.
module tb_half_sub;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=1 instance (also carries the CNT_W=2 counter)
    logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
    logic       d1, bo1, ov1;
    // WIDTH=8 instance
    logic [7:0] a8 = '0, b8 = '0;
    logic       v8 = 1'b0;
    logic [7:0] d8;
    logic       bo8, ov8;
    // WIDTH=4 instance
    logic [3:0] a4 = '0, b4 = '0;
    logic       v4 = 1'b0;
    logic [3:0] d4;
    logic       bo4, ov4;

`ifdef HALF_SUB_BCNT_EN
    logic        clr1 = 1'b0, clr8 = 1'b0, clr4 = 1'b0;
    logic [1:0]  cnt1;
    logic [15:0] cnt8, cnt4;
`endif

    int checks = 0;
    int errors = 0;

    half_sub #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .d(d1), .bo(bo1), .out_valid(ov1)
`ifdef HALF_SUB_BCNT_EN
        , .cnt_clr(clr1), .borrow_cnt(cnt1)
`endif
    );

    half_sub #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .d(d8), .bo(bo8), .out_valid(ov8)
`ifdef HALF_SUB_BCNT_EN
        , .cnt_clr(clr8), .borrow_cnt(cnt8)
`endif
    );

    half_sub #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
        .d(d4), .bo(bo4), .out_valid(ov4)
`ifdef HALF_SUB_BCNT_EN
        , .cnt_clr(clr4), .borrow_cnt(cnt4)
`endif
    );

    // One clock edge, then settle before sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        tick();
        checks++;
        if ({d1, bo1, ov1} !== 3'b000) begin
            errors++;
            $display("FAIL reset_w1 got d=%b bo=%b ov=%b want 0 0 0", d1, bo1, ov1);
        end
        checks++;
        if ({d8, bo8, ov8} !== 10'h000) begin
            errors++;
            $display("FAIL reset_w8 got d=%h bo=%b ov=%b want 00 0 0", d8, bo8, ov8);
        end
        checks++;
        if ({d4, bo4, ov4} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_w4 got d=%h bo=%b ov=%b want 0 0 0", d4, bo4, ov4);
        end
`ifdef HALF_SUB_BCNT_EN
        checks++;
        if (cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", cnt1);
        end
`endif
        v1 = 1'b0;
        rst = 1'b0;
    endtask

    // WIDTH=1 truth table, back to back, starting on the first edge after reset.
    task automatic test_w1_truth();
        logic exp_d[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_bo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            a1 = (i >= 2);
            b1 = (i % 2 == 1);
            v1 = 1'b1;
            tick();
            checks++;
            if (d1 !== exp_d[i] || bo1 !== exp_bo[i] || ov1 !== 1'b1) begin
                errors++;
                $display("FAIL w1_truth[%0d] got d=%b bo=%b ov=%b want %b %b 1",
                         i, d1, bo1, ov1, exp_d[i], exp_bo[i]);
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_w8();
        a8 = 8'h05; b8 = 8'h07; v8 = 1'b1;
        tick();
        checks++;
        if (d8 !== 8'hFE || bo8 !== 1'b1 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL w8_borrow got d=%h bo=%b ov=%b want fe 1 1", d8, bo8, ov8);
        end
        a8 = 8'hFF; b8 = 8'h01;
        tick();
        checks++;
        if (d8 !== 8'hFE || bo8 !== 1'b0 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL w8_noborrow got d=%h bo=%b ov=%b want fe 0 1", d8, bo8, ov8);
        end
        v8 = 1'b0;
        tick();
        checks++;
        if (d8 !== 8'hFE || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_idle got d=%h ov=%b want fe 0", d8, ov8);
        end
    endtask

    // Hold with idle inputs, including unknown operands.
    task automatic test_hold();
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        tick();
        checks++;
        if (d1 !== 1'b1 || bo1 !== 1'b1 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL hold_load got d=%b bo=%b ov=%b want 1 1 1", d1, bo1, ov1);
        end
        v1 = 1'b0; a1 = 1'bx; b1 = 1'bz;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d1 !== 1'b1 || bo1 !== 1'b1 || ov1 !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got d=%b bo=%b ov=%b want 1 1 0", i, d1, bo1, ov1);
            end
        end
        a1 = 1'b0; b1 = 1'b0;
    endtask

    // Reset coinciding with a valid input discards the input.
    task automatic test_rst_discard();
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        tick();
        checks++;
        if (d1 !== 1'b0 || bo1 !== 1'b0 || ov1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard got d=%b bo=%b ov=%b want 0 0 0", d1, bo1, ov1);
        end
        rst = 1'b0;
        v1 = 1'b0;
    endtask

`ifdef HALF_SUB_BCNT_EN
    task automatic test_counter();
        logic [1:0] exp_cnt[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1; clr1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cnt1 !== exp_cnt[i]) begin
                errors++;
                $display("FAIL cnt_sat[%0d] got %0d want %0d", i, cnt1, exp_cnt[i]);
            end
        end
        clr1 = 1'b1;
        tick();
        checks++;
        if (cnt1 !== 2'd0 || bo1 !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clr got cnt=%0d bo=%b want 0 1", cnt1, bo1);
        end
        clr1 = 1'b0;
        v1 = 1'b0;
        tick();
        checks++;
        if (cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_idle got %0d want 0", cnt1);
        end
    endtask
`endif

    // Random WIDTH=4 traffic against an independent one-cycle reference.
    task automatic test_random();
        logic [3:0] md = '0;
        logic       mb = 1'b0;
        logic       mv = 1'b0;
        int         bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            v4 = 1'($urandom_range(0, 1));
            if (v4) begin
                md = 4'((int'(a4) - int'(b4) + 16) % 16);
                mb = (int'(a4) < int'(b4));
            end
            mv = v4;
            tick();
            checks++;
            if (d4 !== md || bo4 !== mb || ov4 !== mv) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand[%0d] got d=%h bo=%b ov=%b want %h %b %b",
                             i, d4, bo4, ov4, md, mb, mv);
            end
        end
        v4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_w1_truth();
        test_w8();
        test_hold();
        test_rst_discard();
`ifdef HALF_SUB_BCNT_EN
        test_counter();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
